// File: rtl/flag_cross_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// flag_sched_pkg
// Shared types and constants for the flag-crossing scheduler.
//   flag_sched_state_e : scheduler FSM states (IDLE, ISSUE, HOLD)
//   DROP_MAX           : saturation value of the dropped-request counter
// ---------------------------------------------------------------------------
package flag_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } flag_sched_state_e;

   localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/flag_cross_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the pending vector starting one
// position after the last winner, wrapping around, and reports the first set
// bit.
//   pending [NUM_REQ-1:0] in  : candidate requesters
//   last    [ID_W-1:0]    in  : index of the previous winner
//   valid                 out : at least one candidate is pending
//   index   [ID_W-1:0]    out : winning requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick
   import flag_sched_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [ID_W-1:0]    last,
   output logic               valid,
   output logic [ID_W-1:0]    index
);

   // Walk the offsets from farthest to nearest so that the nearest pending
   // requester after 'last' is the one left standing when the loop ends.
   always_comb begin
      logic [ID_W-1:0] cand;
      cand  = '0;
      valid = 1'b0;
      index = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = ID_W'((int'(last) + off) % NUM_REQ);
         if (pending[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/flag_cross_scheduler.sv
// ---------------------------------------------------------------------------
// flag_cross_scheduler
// Source-domain scheduler sharing one single-bit flag crossing among NUM_REQ
// requesters. One-clock request pulses are latched as pending bits, granted
// round-robin, and issued as one-clock flag_out pulses spaced at least GAP
// clocks apart. id_out names the granted requester and is held until the
// next grant so the destination can sample it after the crossed flag.
//
// Optional feature macro: FLAG_SCHED_ACK_EN
//   When defined, an ack_in port exists and HOLD additionally waits for a
//   completion pulse from the destination before the next grant.
//
// Ports:
//   clk         in  : source-domain clock
//   reset       in  : asynchronous active-high reset
//   req         in  : one-clock request pulses, one bit per requester
//   ack_in      in  : synchronized completion pulse (FLAG_SCHED_ACK_EN only)
//   flag_out    out : one-clock pulse into the flag crossing
//   id_out      out : index of the last granted requester
//   pending     out : latched, not-yet-granted requests
//   busy        out : high while in ISSUE or HOLD
//   drop_count  out : saturating count of cycles in which a request was lost
// ---------------------------------------------------------------------------
module flag_cross_scheduler
   import flag_sched_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  GAP     = 8,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
`ifdef FLAG_SCHED_ACK_EN
   input  logic               ack_in,
`endif
   output logic               flag_out,
   output logic [ID_W-1:0]    id_out,
   output logic [NUM_REQ-1:0] pending,
   output logic               busy,
   output logic [7:0]         drop_count
);

   flag_sched_state_e state;
   flag_sched_state_e state_next;

   logic [ID_W-1:0]    last_grant;
   logic [7:0]         gap_cnt;
   logic               pick_valid;
   logic [ID_W-1:0]    pick_index;
   logic               grant;
   logic [NUM_REQ-1:0] grant_mask;
   logic               hold_done;
   logic               drop_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .pending (pending),
      .last    (last_grant),
      .valid   (pick_valid),
      .index   (pick_index)
   );

`ifdef FLAG_SCHED_ACK_EN
   logic ack_seen;

   // Sticky record that the destination acknowledged the current flag; it is
   // cleared by the grant that starts the next ISSUE so each flag needs its
   // own acknowledgement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_seen <= 1'b0;
      end else if (grant) begin
         ack_seen <= 1'b0;
      end else if (state == HOLD && ack_in) begin
         ack_seen <= 1'b1;
      end
   end

   assign hold_done = (gap_cnt == 8'd0) && ack_seen;
`else
   assign hold_done = (gap_cnt == 8'd0);
`endif

   // Next-state and grant decision. The last HOLD cycle may grant directly so
   // that consecutive ISSUE cycles are exactly GAP clocks apart under load;
   // without pending work HOLD falls back to IDLE.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = HOLD;
         end
         HOLD: begin
            if (hold_done) begin
               if (pick_valid) begin
                  grant      = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One-hot of the requester being granted this cycle, and detection of a
   // request that collides with a bit that stays pending.
   always_comb begin
      grant_mask = '0;
      if (grant) begin
         grant_mask[pick_index] = 1'b1;
      end
      drop_any = |(req & pending & ~grant_mask);
   end

   // State register plus registered flag/busy/id outputs. flag_out and busy
   // are loaded from the next state so they are clean flop outputs aligned
   // with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         flag_out   <= 1'b0;
         busy       <= 1'b0;
         id_out     <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
      end else begin
         state    <= state_next;
         flag_out <= (state_next == ISSUE);
         busy     <= (state_next != IDLE);
         if (grant) begin
            id_out     <= pick_index;
            last_grant <= pick_index;
         end
      end
   end

   // Gap counter: loaded while leaving ISSUE so HOLD starts at GAP-2 and
   // reaches zero in the final HOLD cycle of the spacing window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap_cnt <= '0;
      end else if (state == ISSUE) begin
         gap_cnt <= 8'(GAP - 2);
      end else if (state == HOLD && gap_cnt != 8'd0) begin
         gap_cnt <= gap_cnt - 8'd1;
      end
   end

   // Pending bits: the winner is cleared on its grant edge, while a request
   // arriving in that same cycle is re-latched so it is not lost. Any
   // collision with a bit that stays pending counts once per cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending    <= '0;
         drop_count <= '0;
      end else begin
         pending <= (pending & ~grant_mask) | req;
         if (drop_any && drop_count != DROP_MAX) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_flag_cross_scheduler.sv
// ---------------------------------------------------------------------------
// tb_flag_cross_scheduler
// Self-checking bench for flag_cross_scheduler (NUM_REQ=4, GAP=8).
// A timeline model tracks pending requests, the round-robin pointer and the
// cycle at which the scheduler is next free, and every output is compared
// against it on each falling edge. Directed scenarios add literal
// expectations for pulse cycles, ids and counters. Honours
// FLAG_SCHED_ACK_EN for the acknowledged-HOLD variant.
// ---------------------------------------------------------------------------
module tb_flag_cross_scheduler;

   localparam int NUM_REQ = 4;
   localparam int GAP     = 8;
   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int BIG     = 1 << 30;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_REQ-1:0] req;
`ifdef FLAG_SCHED_ACK_EN
   logic               ack_in;
`endif
   logic               flag_out;
   logic [ID_W-1:0]    id_out;
   logic [NUM_REQ-1:0] pending;
   logic               busy;
   logic [7:0]         drop_count;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   // Timeline model state
   bit m_pend [NUM_REQ];
   int m_last;
   int m_id;
   int m_drop;
   int m_cyc;
   int m_issue;
   int m_hold_end;
   bit m_ack_seen;
   bit exp_flag;
   bit exp_busy;

   // Pulse capture for directed checks
   int np;
   int pc  [16];
   int pid [16];

   flag_cross_scheduler #(
      .NUM_REQ (NUM_REQ),
      .GAP     (GAP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
`ifdef FLAG_SCHED_ACK_EN
      .ack_in     (ack_in),
`endif
      .flag_out   (flag_out),
      .id_out     (id_out),
      .pending    (pending),
      .busy       (busy),
      .drop_count (drop_count)
   );

   // Free-running source clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelInit();
      for (int i = 0; i < NUM_REQ; i++) m_pend[i] = 1'b0;
      m_last     = NUM_REQ - 1;
      m_id       = 0;
      m_drop     = 0;
      m_issue    = -1000;
      m_hold_end = -1;
      m_ack_seen = 1'b0;
      exp_flag   = 1'b0;
      exp_busy   = 1'b0;
   endtask

   // Advance the model across one rising edge, using the inputs of cycle
   // m_cyc. The scheduler may grant once m_cyc reaches the last cycle of the
   // current spacing window (m_hold_end).
   task automatic modelStep();
      int win;
      int idx;
      bit dropped;
      win     = -1;
      dropped = 1'b0;
`ifdef FLAG_SCHED_ACK_EN
      if (ack_in && !m_ack_seen && m_cyc > m_issue && m_cyc <= m_hold_end) begin
         m_ack_seen = 1'b1;
         m_hold_end = (m_issue + GAP - 1 > m_cyc + 1) ? (m_issue + GAP - 1) : (m_cyc + 1);
      end
`endif
      if (m_cyc >= m_hold_end) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_last + k) % NUM_REQ;
            if (win < 0 && m_pend[idx]) win = idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && m_pend[i] && i != win) dropped = 1'b1;
      end
      if (dropped && m_drop < 255) m_drop++;
      if (win >= 0) m_pend[win] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i]) m_pend[i] = 1'b1;
      end
      if (win >= 0) begin
         m_id    = win;
         m_last  = win;
         m_issue = m_cyc + 1;
`ifdef FLAG_SCHED_ACK_EN
         m_hold_end = BIG;
         m_ack_seen = 1'b0;
`else
         m_hold_end = m_cyc + GAP;
`endif
      end
      m_cyc++;
      exp_flag = (m_cyc == m_issue);
      exp_busy = (m_cyc >= m_issue) && (m_cyc <= m_hold_end);
   endtask

   // Model advances on every rising edge and collapses on reset.
   initial begin
      m_cyc = 0;
      modelInit();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) modelInit();
         else modelStep();
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      int exp_pend;
      forever begin
         @(negedge clk);
         if (check_en) begin
            exp_pend = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (m_pend[i]) exp_pend = exp_pend | (1 << i);
            end
            checkOutput("model_flag_out", int'(flag_out), int'(exp_flag));
            checkOutput("model_id_out", int'(id_out), m_id);
            checkOutput("model_pending", int'(pending), exp_pend);
            checkOutput("model_busy", int'(busy), int'(exp_busy));
            checkOutput("model_drop_count", int'(drop_count), m_drop);
         end
      end
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      waitCycles(2);
      reset = 1'b0;
   endtask

   // Drive a request pattern for n cycles starting at the current falling
   // edge; returns at the falling edge n cycles later with req cleared.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] pattern, input int n);
      req = pattern;
      waitCycles(n);
      req = '0;
   endtask

   // Record flag_out pulses over ncyc cycles; first_cycle labels the current
   // falling edge.
   task automatic collectPulses(input int first_cycle, input int ncyc);
      np = 0;
      for (int c = first_cycle; c < first_cycle + ncyc; c++) begin
         if (flag_out) begin
            if (np < 16) begin
               pc[np]  = c;
               pid[np] = int'(id_out);
            end
            np++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int bc;
      reset = 1'b1;
      req   = '0;
`ifdef FLAG_SCHED_ACK_EN
      ack_in = 1'b1;
`endif
      resetDut();
      check_en = 1'b1;

      // Reset values
      checkOutput("reset_flag_out", int'(flag_out), 0);
      checkOutput("reset_id_out", int'(id_out), 0);
      checkOutput("reset_pending", int'(pending), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_drop_count", int'(drop_count), 0);

      // Single request: pending in cycle 1, pulse in cycle 2, busy for GAP
      applyStimulus(4'b0001, 1);
      checkOutput("t1_pending_c1", int'(pending), 1);
      waitCycles(1);
      checkOutput("t1_flag_c2", int'(flag_out), 1);
      checkOutput("t1_id_c2", int'(id_out), 0);
      checkOutput("t1_pending_c2", int'(pending), 0);
      bc = 0;
      for (int t = 0; t < 12; t++) begin
         if (busy) bc++;
         @(negedge clk);
      end
      checkOutput("t1_busy_cycles", bc, GAP);

      // All four at once: pulses every GAP cycles in round-robin order
      resetDut();
      applyStimulus(4'b1111, 1);
      collectPulses(1, 40);
      checkOutput("t2_pulse_count", np, 4);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t2_pulse%0d_cycle", k), pc[k], 2 + k * GAP);
         checkOutput($sformatf("t2_pulse%0d_id", k), pid[k], k);
      end
      checkOutput("t2_drop_count", int'(drop_count), 0);

      // Repeated request while pending: one grant, one drop, then saturate
      resetDut();
      applyStimulus(4'b0001, 1);
      waitCycles(2);
      applyStimulus(4'b0010, 1);
      applyStimulus(4'b0010, 1);
      collectPulses(5, 30);
      checkOutput("t3_pulse_count", np, 1);
      checkOutput("t3_pulse_cycle", pc[0], 10);
      checkOutput("t3_pulse_id", pid[0], 1);
      checkOutput("t3_drop_one", int'(drop_count), 1);
      applyStimulus(4'b0010, 320);
      waitCycles(2);
      checkOutput("t3_drop_saturated", int'(drop_count), 255);

      // Request in the same cycle as its own grant is kept and re-granted
      resetDut();
      applyStimulus(4'b0100, 2);
      checkOutput("t4_flag_c2", int'(flag_out), 1);
      checkOutput("t4_id_c2", int'(id_out), 2);
      checkOutput("t4_pending_kept", int'(pending), 4);
      collectPulses(2, 20);
      checkOutput("t4_pulse_count", np, 2);
      checkOutput("t4_pulse1_cycle", pc[1], 2 + GAP);
      checkOutput("t4_pulse1_id", pid[1], 2);
      checkOutput("t4_drop_count", int'(drop_count), 0);

      // Asynchronous reset during HOLD discards pending work
      resetDut();
      applyStimulus(4'b0010, 1);
      waitCycles(2);
      applyStimulus(4'b0110, 1);
      checkOutput("t5_pending_before", int'(pending), 6);
      checkOutput("t5_id_before", int'(id_out), 1);
      waitCycles(1);
      checkOutput("t5_busy_before", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t5_async_flag", int'(flag_out), 0);
      checkOutput("t5_async_id", int'(id_out), 0);
      checkOutput("t5_async_pending", int'(pending), 0);
      checkOutput("t5_async_busy", int'(busy), 0);
      checkOutput("t5_async_drop", int'(drop_count), 0);
      waitCycles(2);
      reset = 1'b0;
      applyStimulus(4'b1000, 1);
      waitCycles(1);
      checkOutput("t5_flag_after", int'(flag_out), 1);
      checkOutput("t5_id_after", int'(id_out), 3);
      waitCycles(GAP);

`ifdef FLAG_SCHED_ACK_EN
      // Late acknowledgement: second pulse two cycles after ack_in
      ack_in = 1'b0;
      resetDut();
      applyStimulus(4'b0011, 1);
      waitCycles(21);
      ack_in = 1'b1;
      waitCycles(1);
      ack_in = 1'b0;
      collectPulses(23, 10);
      checkOutput("t6_late_count", np, 1);
      checkOutput("t6_late_cycle", pc[0], 24);
      checkOutput("t6_late_id", pid[0], 1);

      // Early acknowledgement: spacing still at least GAP
      resetDut();
      applyStimulus(4'b0011, 1);
      waitCycles(3);
      ack_in = 1'b1;
      waitCycles(1);
      ack_in = 1'b0;
      collectPulses(5, 20);
      checkOutput("t6_early_count", np, 1);
      checkOutput("t6_early_cycle", pc[0], 2 + GAP);
      checkOutput("t6_early_id", pid[0], 1);
`endif

      waitCycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
